// File: rtl/lc3_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder_if
//   Bundle of the LC3 split instruction/data memory bus plus the backdoor
//   load port.
//   master : core/bench side, drives requests and the backdoor port
//   slave  : memory responder side, returns read data and completion pulses
// Signals
//   pc, instrmem_rd                 instruction fetch address / request
//   Instr_dout, complete_instr      fetched word / one-cycle completion pulse
//   data_req, Data_addr, Data_rd,
//   Data_din                        data access request, address, 1=read, wdata
//   Data_dout, complete_data        read data / one-cycle completion pulse
//   load_en, load_addr, load_data   backdoor array write
// ---------------------------------------------------------------------------
interface lc3_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic              instrmem_rd;
  logic [15:0]       Instr_dout;
  logic              complete_instr;
  logic              data_req;
  logic [ADDR_W-1:0] Data_addr;
  logic              Data_rd;
  logic [15:0]       Data_din;
  logic [15:0]       Data_dout;
  logic              complete_data;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;

  modport master (
    output pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
    output load_en, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, data_req, Data_addr, Data_rd, Data_din,
    input  load_en, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder
//   Memory-side responder for the LC3 split instruction/data interface.
//   One shared 16-bit array of 2**ADDR_W words, served by two independent
//   wait-state FSMs (instruction port, data port) plus a backdoor load port.
// Ports
//   clock  : rising-edge clock
//   reset  : synchronous active-high; clears FSMs and outputs, not the array
//   bus    : lc3_mem_responder_if.slave (fetch, data, backdoor load signals)
// Parameters
//   ADDR_W     : address width
//   INSTR_WAIT : wait cycles before each instruction response (0..255)
//   DATA_WAIT  : wait cycles before each data response (0..255)
// ---------------------------------------------------------------------------
module lc3_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int INSTR_WAIT = 0,
  parameter int DATA_WAIT  = 0
) (
  input logic                clock,
  input logic                reset,
  lc3_mem_responder_if.slave bus
);

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] I_WAIT  = 8'(INSTR_WAIT);
  localparam logic [7:0] D_WAIT  = 8'(DATA_WAIT);
  // With no wait states an accepted request goes straight to the response state.
  localparam logic [1:0] I_FIRST = (I_WAIT != 8'd0) ? S_BUSY : S_RESP;
  localparam logic [1:0] D_FIRST = (D_WAIT != 8'd0) ? S_BUSY : S_RESP;

  // Word seen by a read on the response edge: the backdoor load beats a data
  // write, and both beat the stored word (write-first).
  function automatic logic [15:0] read_word(
    input logic [15:0]       stored,
    input logic [ADDR_W-1:0] addr,
    input logic              ld_en,
    input logic [ADDR_W-1:0] ld_addr,
    input logic [15:0]       ld_data,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [15:0]       wr_data
  );
    logic [15:0] word;
    if (ld_en && (ld_addr == addr)) begin
      word = ld_data;
    end else if (wr_en && (wr_addr == addr)) begin
      word = wr_data;
    end else begin
      word = stored;
    end
    return word;
  endfunction

  logic [15:0]       mem_array [DEPTH];

  logic [1:0]        i_state_q, i_state_d;
  logic [7:0]        i_cnt_q, i_cnt_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic              i_resp_s;

  logic [1:0]        d_state_q, d_state_d;
  logic [7:0]        d_cnt_q, d_cnt_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic              d_rd_q, d_rd_d;
  logic [15:0]       d_din_q, d_din_d;
  logic              d_resp_s;

  logic              wr_en_s;
  logic [15:0]       i_rdata_s, d_rdata_s;

  logic              complete_instr_q, complete_instr_d;
  logic              complete_data_q, complete_data_d;
  logic [15:0]       instr_dout_q, instr_dout_d;
  logic [15:0]       data_dout_q, data_dout_d;

  // Instruction port FSM: accept in IDLE/RESP, count wait states in BUSY.
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_addr_d  = i_addr_q;
    i_resp_s  = 1'b0;
    case (i_state_q)
      S_IDLE: begin
        if (bus.instrmem_rd) begin
          i_addr_d  = bus.pc;
          i_cnt_d   = I_WAIT;
          i_state_d = I_FIRST;
        end else begin
          i_state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        i_cnt_d = i_cnt_q - 8'd1;
        if (i_cnt_q == 8'd1) begin
          i_state_d = S_RESP;
        end else begin
          i_state_d = S_BUSY;
        end
      end
      S_RESP: begin
        i_resp_s = 1'b1;
        if (bus.instrmem_rd) begin
          i_addr_d  = bus.pc;
          i_cnt_d   = I_WAIT;
          i_state_d = I_FIRST;
        end else begin
          i_state_d = S_IDLE;
        end
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  // Data port FSM: same shape, also captures direction and write data.
  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_addr_d  = d_addr_q;
    d_rd_d    = d_rd_q;
    d_din_d   = d_din_q;
    d_resp_s  = 1'b0;
    case (d_state_q)
      S_IDLE: begin
        if (bus.data_req) begin
          d_addr_d  = bus.Data_addr;
          d_rd_d    = bus.Data_rd;
          d_din_d   = bus.Data_din;
          d_cnt_d   = D_WAIT;
          d_state_d = D_FIRST;
        end else begin
          d_state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        d_cnt_d = d_cnt_q - 8'd1;
        if (d_cnt_q == 8'd1) begin
          d_state_d = S_RESP;
        end else begin
          d_state_d = S_BUSY;
        end
      end
      S_RESP: begin
        d_resp_s = 1'b1;
        if (bus.data_req) begin
          d_addr_d  = bus.Data_addr;
          d_rd_d    = bus.Data_rd;
          d_din_d   = bus.Data_din;
          d_cnt_d   = D_WAIT;
          d_state_d = D_FIRST;
        end else begin
          d_state_d = S_IDLE;
        end
      end
      default: d_state_d = S_IDLE;
    endcase
  end

  // Array access and response output next-state, with write-first forwarding.
  always_comb begin
    wr_en_s          = d_resp_s & ~d_rd_q & ~reset;
    i_rdata_s        = read_word(mem_array[i_addr_q], i_addr_q, bus.load_en, bus.load_addr,
                                 bus.load_data, wr_en_s, d_addr_q, d_din_q);
    d_rdata_s        = read_word(mem_array[d_addr_q], d_addr_q, bus.load_en, bus.load_addr,
                                 bus.load_data, wr_en_s, d_addr_q, d_din_q);
    complete_instr_d = i_resp_s;
    complete_data_d  = d_resp_s;
    if (i_resp_s) begin
      instr_dout_d = i_rdata_s;
    end else begin
      instr_dout_d = instr_dout_q;
    end
    if (d_resp_s && d_rd_q) begin
      data_dout_d = d_rdata_s;
    end else begin
      data_dout_d = data_dout_q;
    end
  end

  // Shared array; the load is assigned last so it wins a same-address collision.
  // Not reset: contents survive reset and the backdoor works during reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_array[d_addr_q] <= d_din_q;
    end
    if (bus.load_en) begin
      mem_array[bus.load_addr] <= bus.load_data;
    end
  end

  // FSM state, captured request fields and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_state_q        <= S_IDLE;
      i_cnt_q          <= 8'd0;
      i_addr_q         <= '0;
      d_state_q        <= S_IDLE;
      d_cnt_q          <= 8'd0;
      d_addr_q         <= '0;
      d_rd_q           <= 1'b0;
      d_din_q          <= 16'h0000;
      complete_instr_q <= 1'b0;
      complete_data_q  <= 1'b0;
      instr_dout_q     <= 16'h0000;
      data_dout_q      <= 16'h0000;
    end else begin
      i_state_q        <= i_state_d;
      i_cnt_q          <= i_cnt_d;
      i_addr_q         <= i_addr_d;
      d_state_q        <= d_state_d;
      d_cnt_q          <= d_cnt_d;
      d_addr_q         <= d_addr_d;
      d_rd_q           <= d_rd_d;
      d_din_q          <= d_din_d;
      complete_instr_q <= complete_instr_d;
      complete_data_q  <= complete_data_d;
      instr_dout_q     <= instr_dout_d;
      data_dout_q      <= data_dout_d;
    end
  end

  assign bus.complete_instr = complete_instr_q;
  assign bus.Instr_dout     = instr_dout_q;
  assign bus.complete_data  = complete_data_q;
  assign bus.Data_dout      = data_dout_q;

endmodule
